// File: rtl/csr_pkg.sv
// CSR addresses, write masks and privilege encodings shared by the CSR register file.
// Pure definitions; no latency or flow control.
package csr_pkg;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MEDELEG   = 12'h302;
  localparam logic [11:0] CSR_MIDELEG   = 12'h303;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_SSTATUS   = 12'h100;
  localparam logic [11:0] CSR_SIE       = 12'h104;
  localparam logic [11:0] CSR_STVEC     = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH  = 12'h140;
  localparam logic [11:0] CSR_SEPC      = 12'h141;
  localparam logic [11:0] CSR_SCAUSE    = 12'h142;
  localparam logic [11:0] CSR_STVAL     = 12'h143;
  localparam logic [11:0] CSR_SIP       = 12'h144;
  localparam logic [11:0] CSR_SATP      = 12'h180;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [31:0] SSTATUS_MASK  = 32'h000C_0122;
  localparam logic [31:0] MIP_SW_MASK   = 32'h0000_0222;
  localparam logic [31:0] MIP_TRAP_MASK = 32'h0000_02A2;
  localparam logic [31:0] MIP_SSIP      = 32'h0000_0002;
  localparam logic [31:0] XTVEC_MASK    = 32'hFFFF_FFFD;
  localparam logic [31:0] XEPC_MASK     = 32'hFFFF_FFFE;

  function automatic logic csr_implemented(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MEDELEG, CSR_MIDELEG, CSR_MIE, CSR_MTVEC,
      CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
      CSR_SSTATUS, CSR_SIE, CSR_STVEC, CSR_SSCRATCH, CSR_SEPC, CSR_SCAUSE,
      CSR_STVAL, CSR_SIP, CSR_SATP,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: csr_implemented = 1'b1;
      default: csr_implemented = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
    csr_merge = (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half 32-bit write; a write to either half blocks the increment.
// Update visible one cycle after the enable edge; no backpressure.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wen_lo || wen_hi) begin
      if (wen_lo) value[31:0]  <= wdata;
      if (wen_hi) value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_regfile.sv
// M/S-mode CSR storage, privilege level and mcycle/minstret; trap port has write priority.
// Reads combinational, writes visible next cycle; no backpressure (writes always accepted or dropped).
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MISA_VAL    = 32'h4014_1100,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_csr_wen_i,
  input  logic [11:0] trap_csr_waddr_i,
  input  logic [31:0] trap_csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_illegal_o,
  input  logic        priv_wen_i,
  input  logic [1:0]  priv_i,
  output logic [1:0]  privilege_o,
  input  logic        instret_i,
  input  logic        mtip_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_medeleg_o,
  output logic [31:0] csr_mideleg_o,
  output logic [31:0] csr_sstatus_o,
  output logic [31:0] csr_stvec_o,
  output logic [31:0] csr_sepc_o,
  output logic [31:0] csr_scause_o,
  output logic [31:0] csr_stval_o,
  output logic [31:0] csr_sie_o,
  output logic [31:0] csr_sip_o,
  output logic [31:0] csr_satp_o
);

  logic [1:0]  priv_q;
  logic [31:0] mstatus_q, medeleg_q, mideleg_q, mie_q, mtvec_q, mscratch_q;
  logic [31:0] mepc_q, mcause_q, mtval_q, mip_q;
  logic [31:0] stvec_q, sscratch_q, sepc_q, scause_q, stval_q, satp_q;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip_rd, rd_val;
  logic        rd_bad, wr_bad;
  logic        w_en, w_trap;
  logic [11:0] w_addr;
  logic [31:0] w_data;

  assign mip_rd = mip_q | (mtip_i ? 32'h0000_0080 : 32'h0);

  assign rd_bad = !csr_implemented(csr_raddr_i) || (csr_raddr_i[9:8] > priv_q);
  assign wr_bad = !csr_implemented(csr_waddr_i) || (csr_waddr_i[9:8] > priv_q)
                  || (csr_waddr_i[11:10] == 2'b11);
  assign csr_illegal_o = rd_bad || (csr_wen_i && wr_bad);

  // Single merged write port: the trap port pre-empts any instruction write.
  always_comb begin
    w_trap = trap_csr_wen_i;
    w_en   = trap_csr_wen_i || (csr_wen_i && !csr_illegal_o);
    w_addr = trap_csr_wen_i ? trap_csr_waddr_i : csr_waddr_i;
    w_data = trap_csr_wen_i ? trap_csr_wdata_i : csr_wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      priv_q     <= PRV_M;
      mstatus_q  <= MSTATUS_RST;
      medeleg_q  <= '0;
      mideleg_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      stvec_q    <= '0;
      sscratch_q <= '0;
      sepc_q     <= '0;
      scause_q   <= '0;
      stval_q    <= '0;
      satp_q     <= '0;
    end else begin
      if (priv_wen_i) priv_q <= priv_i;
      if (w_en) begin
        case (w_addr)
          CSR_MSTATUS:  mstatus_q  <= w_data;
          CSR_SSTATUS:  mstatus_q  <= csr_merge(mstatus_q, w_data, SSTATUS_MASK);
          CSR_MEDELEG:  medeleg_q  <= w_data;
          CSR_MIDELEG:  mideleg_q  <= w_data;
          CSR_MIE:      mie_q      <= w_data;
          CSR_SIE:      mie_q      <= csr_merge(mie_q, w_data, mideleg_q);
          CSR_MTVEC:    mtvec_q    <= w_data & XTVEC_MASK;
          CSR_MSCRATCH: mscratch_q <= w_data;
          CSR_MEPC:     mepc_q     <= w_data & XEPC_MASK;
          CSR_MCAUSE:   mcause_q   <= w_data;
          CSR_MTVAL:    mtval_q    <= w_data;
          CSR_MIP:      mip_q      <= csr_merge(mip_q, w_data,
                                                w_trap ? MIP_TRAP_MASK : MIP_SW_MASK);
          CSR_SIP:      mip_q      <= csr_merge(mip_q, w_data, mideleg_q & MIP_SSIP);
          CSR_STVEC:    stvec_q    <= w_data & XTVEC_MASK;
          CSR_SSCRATCH: sscratch_q <= w_data;
          CSR_SEPC:     sepc_q     <= w_data & XEPC_MASK;
          CSR_SCAUSE:   scause_q   <= w_data;
          CSR_STVAL:    stval_q    <= w_data;
          CSR_SATP:     satp_q     <= w_data;
          default: ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (1'b1),
    .wen_lo (w_en && (w_addr == CSR_MCYCLE)),
    .wen_hi (w_en && (w_addr == CSR_MCYCLEH)),
    .wdata  (w_data),
    .value  (mcycle)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (instret_i),
    .wen_lo (w_en && (w_addr == CSR_MINSTRET)),
    .wen_hi (w_en && (w_addr == CSR_MINSTRETH)),
    .wdata  (w_data),
    .value  (minstret)
  );

  always_comb begin
    rd_val = '0;
    case (csr_raddr_i)
      CSR_MSTATUS:                rd_val = mstatus_q;
      CSR_MISA:                   rd_val = MISA_VAL;
      CSR_MEDELEG:                rd_val = medeleg_q;
      CSR_MIDELEG:                rd_val = mideleg_q;
      CSR_MIE:                    rd_val = mie_q;
      CSR_MTVEC:                  rd_val = mtvec_q;
      CSR_MSCRATCH:               rd_val = mscratch_q;
      CSR_MEPC:                   rd_val = mepc_q;
      CSR_MCAUSE:                 rd_val = mcause_q;
      CSR_MTVAL:                  rd_val = mtval_q;
      CSR_MIP:                    rd_val = mip_rd;
      CSR_SSTATUS:                rd_val = mstatus_q & SSTATUS_MASK;
      CSR_SIE:                    rd_val = mie_q & mideleg_q;
      CSR_STVEC:                  rd_val = stvec_q;
      CSR_SSCRATCH:               rd_val = sscratch_q;
      CSR_SEPC:                   rd_val = sepc_q;
      CSR_SCAUSE:                 rd_val = scause_q;
      CSR_STVAL:                  rd_val = stval_q;
      CSR_SIP:                    rd_val = mip_rd & mideleg_q;
      CSR_SATP:                   rd_val = satp_q;
      CSR_MCYCLE,   CSR_CYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
      default: ;
    endcase
  end

  assign csr_rdata_o   = csr_illegal_o ? 32'h0 : rd_val;
  assign privilege_o   = priv_q;
  assign csr_mstatus_o = mstatus_q;
  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mcause_o  = mcause_q;
  assign csr_mtval_o   = mtval_q;
  assign csr_mie_o     = mie_q;
  assign csr_mip_o     = mip_rd;
  assign csr_medeleg_o = medeleg_q;
  assign csr_mideleg_o = mideleg_q;
  assign csr_sstatus_o = mstatus_q & SSTATUS_MASK;
  assign csr_stvec_o   = stvec_q;
  assign csr_sepc_o    = sepc_q;
  assign csr_scause_o  = scause_q;
  assign csr_stval_o   = stval_q;
  assign csr_sie_o     = mie_q & mideleg_q;
  assign csr_sip_o     = mip_rd & mideleg_q;
  assign csr_satp_o    = satp_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: directed scenarios followed by randomized traffic,
// expected views come from an address-keyed reference model.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_csr_wen_i = 1'b0;
  logic [11:0] trap_csr_waddr_i = '0;
  logic [31:0] trap_csr_wdata_i = '0;
  logic [11:0] csr_raddr_i = 12'h300;
  logic [31:0] csr_rdata_o;
  logic        csr_wen_i = 1'b0;
  logic [11:0] csr_waddr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic        csr_illegal_o;
  logic        priv_wen_i = 1'b0;
  logic [1:0]  priv_i = '0;
  logic [1:0]  privilege_o;
  logic        instret_i = 1'b0;
  logic        mtip_i = 1'b0;
  logic [31:0] csr_mstatus_o, csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o;
  logic [31:0] csr_mie_o, csr_mip_o, csr_medeleg_o, csr_mideleg_o;
  logic [31:0] csr_sstatus_o, csr_stvec_o, csr_sepc_o, csr_scause_o, csr_stval_o;
  logic [31:0] csr_sie_o, csr_sip_o, csr_satp_o;

  always #5 clk = ~clk;

  csr_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .trap_csr_wen_i(trap_csr_wen_i), .trap_csr_waddr_i(trap_csr_waddr_i),
    .trap_csr_wdata_i(trap_csr_wdata_i),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
    .csr_wen_i(csr_wen_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .csr_illegal_o(csr_illegal_o),
    .priv_wen_i(priv_wen_i), .priv_i(priv_i), .privilege_o(privilege_o),
    .instret_i(instret_i), .mtip_i(mtip_i),
    .csr_mstatus_o(csr_mstatus_o), .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o),
    .csr_mcause_o(csr_mcause_o), .csr_mtval_o(csr_mtval_o), .csr_mie_o(csr_mie_o),
    .csr_mip_o(csr_mip_o), .csr_medeleg_o(csr_medeleg_o), .csr_mideleg_o(csr_mideleg_o),
    .csr_sstatus_o(csr_sstatus_o), .csr_stvec_o(csr_stvec_o), .csr_sepc_o(csr_sepc_o),
    .csr_scause_o(csr_scause_o), .csr_stval_o(csr_stval_o), .csr_sie_o(csr_sie_o),
    .csr_sip_o(csr_sip_o), .csr_satp_o(csr_satp_o)
  );

  localparam int NV = 20;
  typedef logic [NV*32-1:0] vec_t;
  vec_t sb[$];
  int total = 0, bad = 0, pushed = 0, popped = 0;
  string names[NV] = '{"rdata", "illegal", "priv", "mstatus", "mtvec", "mepc", "mcause",
                       "mtval", "mip", "mie", "mideleg", "medeleg", "sstatus", "sie", "sip",
                       "stvec", "sepc", "scause", "stval", "satp"};
  int addrs[36] = '{'h300, 'h301, 'h302, 'h303, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343,
                    'h344, 'h100, 'h104, 'h105, 'h140, 'h141, 'h142, 'h143, 'h144, 'h180,
                    'hB00, 'hB80, 'hB02, 'hB82, 'hC00, 'hC80, 'hC02, 'hC82,
                    'h7C0, 'h3FF, 'h106, 'hF11, 'h200, 'h000, 'h344, 'h303};
  int stored[16] = '{'h300, 'h302, 'h303, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344,
                     'h105, 'h140, 'h141, 'h142, 'h143, 'h180};

  // Reference model: storage keyed by CSR address, counters as plain 64-bit numbers.
  bit [31:0] st [int];
  bit [63:0] cyc, ins;
  bit [1:0]  prv;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    st.delete();
    foreach (stored[i]) st[stored[i]] = 32'h0;
    st['h300] = 32'h0000_1800;
    cyc = 0;
    ins = 0;
    prv = 2'b11;
  endtask

  function automatic bit m_impl(int a);
    return st.exists(a) || (a inside {'h100, 'h104, 'h144, 'h301, 'hB00, 'hB80, 'hB02,
                                      'hB82, 'hC00, 'hC80, 'hC02, 'hC82});
  endfunction

  function automatic bit m_bad_rd(int a);
    return !m_impl(a) || (((a >> 8) & 3) > int'(prv));
  endfunction

  function automatic bit m_bad_wr(int a);
    return m_bad_rd(a) || (((a >> 10) & 3) == 3);
  endfunction

  function automatic bit m_illegal();
    return m_bad_rd(int'(csr_raddr_i)) || (csr_wen_i && m_bad_wr(int'(csr_waddr_i)));
  endfunction

  function automatic bit [31:0] m_mip();
    return st['h344] | (mtip_i ? 32'h80 : 32'h0);
  endfunction

  function automatic bit [31:0] m_read(int a);
    case (a)
      'h301: return 32'h4014_1100;
      'h100: return st['h300] & 32'h000C_0122;
      'h104: return st['h304] & st['h303];
      'h144: return m_mip() & st['h303];
      'h344: return m_mip();
      'hB00, 'hC00: return cyc[31:0];
      'hB80, 'hC80: return cyc[63:32];
      'hB02, 'hC02: return ins[31:0];
      'hB82, 'hC82: return ins[63:32];
      default: return st.exists(a) ? st[a] : 32'h0;
    endcase
  endfunction

  task automatic m_write(int a, bit [31:0] d, bit trap);
    bit [31:0] mk;
    int t;
    t = a;
    mk = 32'hFFFF_FFFF;
    case (a)
      'h100: begin t = 'h300; mk = 32'h000C_0122; end
      'h104: begin t = 'h304; mk = st['h303]; end
      'h144: begin t = 'h344; mk = st['h303] & 32'h2; end
      'h344: mk = trap ? 32'h2A2 : 32'h222;
      'h305, 'h105: mk = 32'hFFFF_FFFD;
      'h341, 'h141: mk = 32'hFFFF_FFFE;
      'hB00: cyc[31:0] = d;
      'hB80: cyc[63:32] = d;
      'hB02: ins[31:0] = d;
      'hB82: ins[63:32] = d;
      default: ;
    endcase
    if (st.exists(t)) st[t] = (st[t] & ~mk) | (d & mk);
  endtask

  task automatic m_tick();
    int wa;
    bit [31:0] wd;
    bit tr;
    wa = -1;
    wd = 0;
    tr = 0;
    if (trap_csr_wen_i) begin
      wa = int'(trap_csr_waddr_i); wd = trap_csr_wdata_i; tr = 1;
    end else if (csr_wen_i && !m_illegal()) begin
      wa = int'(csr_waddr_i); wd = csr_wdata_i;
    end
    if (wa >= 0) m_write(wa, wd, tr);
    if (!(wa inside {'hB00, 'hB80})) cyc = cyc + 1;
    if (!(wa inside {'hB02, 'hB82}) && instret_i) ins = ins + 1;
    if (priv_wen_i) prv = priv_i;
  endtask

  function automatic vec_t m_view();
    bit ill;
    ill = m_illegal();
    return {ill ? 32'h0 : m_read(int'(csr_raddr_i)), {31'b0, ill}, {30'b0, prv},
            m_read('h300), m_read('h305), m_read('h341), m_read('h342), m_read('h343),
            m_read('h344), m_read('h304), m_read('h303), m_read('h302), m_read('h100),
            m_read('h104), m_read('h144), m_read('h105), m_read('h141), m_read('h142),
            m_read('h143), m_read('h180)};
  endfunction

  // Issue one cycle: record what the DUT must show this cycle, then advance the model.
  task automatic step();
    sb.push_back(m_view());
    pushed++;
    @(posedge clk);
    if (rst_n) m_tick();
    #1;
  endtask

  task automatic idle_in();
    trap_csr_wen_i = 0; csr_wen_i = 0; priv_wen_i = 0; instret_i = 0; mtip_i = 0;
    csr_raddr_i = 12'h300;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    vec_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        a = {csr_rdata_o, {31'b0, csr_illegal_o}, {30'b0, privilege_o}, csr_mstatus_o,
             csr_mtvec_o, csr_mepc_o, csr_mcause_o, csr_mtval_o, csr_mip_o, csr_mie_o,
             csr_mideleg_o, csr_medeleg_o, csr_sstatus_o, csr_sie_o, csr_sip_o,
             csr_stvec_o, csr_sepc_o, csr_scause_o, csr_stval_o, csr_satp_o};
        for (int i = 0; i < NV; i++)
          chk(names[i], a[(NV-1-i)*32 +: 32], e[(NV-1-i)*32 +: 32]);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    csr_raddr_i = 12'h301;
    step();
    chk("rst_misa", csr_rdata_o, 32'h4014_1100);
    chk("rst_priv", {30'b0, privilege_o}, 32'h3);
    chk("rst_mstatus", csr_mstatus_o, 32'h0000_1800);
    rst_n = 1;
    idle_in();
    step();

    csr_wen_i = 1; csr_waddr_i = 12'h100; csr_wdata_i = 32'hFFFF_FFFF; csr_raddr_i = 12'h100;
    step();
    chk("sstatus_wr", csr_mstatus_o, 32'h000C_1922);

    idle_in();
    trap_csr_wen_i = 1; trap_csr_waddr_i = 12'h341; trap_csr_wdata_i = 32'h8000_0103;
    csr_wen_i = 1; csr_waddr_i = 12'h341; csr_wdata_i = 32'h0000_1234;
    step();
    chk("trap_wins", csr_mepc_o, 32'h8000_0102);

    idle_in();
    priv_wen_i = 1; priv_i = 2'b00;
    step();
    idle_in();
    csr_wen_i = 1; csr_waddr_i = 12'h305; csr_wdata_i = 32'hFFFF_FFFF; csr_raddr_i = 12'h305;
    #1 chk("u_mtvec_ill", {31'b0, csr_illegal_o}, 32'h1);
    step();
    chk("u_mtvec_keep", csr_mtvec_o, 32'h0);
    idle_in();
    priv_wen_i = 1; priv_i = 2'b11;
    step();
    idle_in();
    csr_wen_i = 1; csr_waddr_i = 12'hC00; csr_wdata_i = 32'h5; csr_raddr_i = 12'hC00;
    #1 chk("ro_cycle_ill", {31'b0, csr_illegal_o}, 32'h1);
    step();

    idle_in();
    csr_wen_i = 1; csr_waddr_i = 12'hB00; csr_wdata_i = 32'hFFFF_FFFE; csr_raddr_i = 12'hB00;
    step();
    idle_in();
    repeat (3) step();
    csr_raddr_i = 12'hB00;
    #1 chk("mcycle_lo", csr_rdata_o, 32'h1);
    csr_raddr_i = 12'hB80;
    #1 chk("mcycle_hi", csr_rdata_o, 32'h1);
    rst_n = 0;
    model_reset();
    #1 chk("mcycle_rst", csr_rdata_o, 32'h0);
    csr_wen_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 32'h5; csr_raddr_i = 12'h340;
    step();
    rst_n = 1;
    idle_in();
    step();

    mtip_i = 1; csr_raddr_i = 12'h344;
    #1 chk("mtip_view", csr_mip_o, 32'h80);
    csr_wen_i = 1; csr_waddr_i = 12'h344; csr_wdata_i = 32'h80;
    step();
    idle_in();
    #1 chk("mip7_sw_keep", csr_mip_o, 32'h0);
    step();

    for (int n = 0; n < 800; n++) begin
      idle_in();
      csr_raddr_i      = 12'(addrs[$urandom_range(0, 35)]);
      csr_wen_i        = 1'($urandom_range(0, 1));
      csr_waddr_i      = ($urandom_range(0, 1) == 1) ? csr_raddr_i
                                                      : 12'(addrs[$urandom_range(0, 35)]);
      csr_wdata_i      = $urandom;
      trap_csr_wen_i   = ($urandom_range(0, 5) == 0);
      trap_csr_waddr_i = 12'(addrs[$urandom_range(0, 35)]);
      trap_csr_wdata_i = $urandom;
      priv_wen_i       = ($urandom_range(0, 7) == 0);
      priv_i           = 2'($urandom_range(0, 3));
      instret_i        = 1'($urandom_range(0, 1));
      mtip_i           = ($urandom_range(0, 3) == 0);
      step();
    end

    idle_in();
    @(negedge clk); #1;
    chk("drain", popped, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
